// File: rtl/jtag_tap_pkg.sv
// Shared TAP types: 1149.1 state encoding, opcode values and the instruction decoder.
package jtag_tap_pkg;

  typedef enum logic [3:0] {
    TLR        = 4'd0,
    RTI        = 4'd1,
    SELECT_DR  = 4'd2,
    CAPTURE_DR = 4'd3,
    SHIFT_DR   = 4'd4,
    EXIT1_DR   = 4'd5,
    PAUSE_DR   = 4'd6,
    EXIT2_DR   = 4'd7,
    UPDATE_DR  = 4'd8,
    SELECT_IR  = 4'd9,
    CAPTURE_IR = 4'd10,
    SHIFT_IR   = 4'd11,
    EXIT1_IR   = 4'd12,
    PAUSE_IR   = 4'd13,
    EXIT2_IR   = 4'd14,
    UPDATE_IR  = 4'd15
  } tap_state_t;

  localparam int EXTEST    = 0;
  localparam int SAMPLE    = 1;
  localparam int IDCODE    = 2;
  localparam int USER_BASE = 3;

  typedef enum logic [2:0] {
    OP_EXTEST,
    OP_SAMPLE,
    OP_IDCODE,
    OP_USER,
    OP_BYPASS
  } op_kind_t;

  typedef struct packed {
    op_kind_t   kind;
    logic [1:0] user_idx;
  } op_dec_t;

  // Anything that is not a defined opcode falls back to BYPASS.
  function automatic op_dec_t opcode_decode(input logic [7:0] op, input int ir_width,
                                            input int num_udr);
    op_dec_t    d;
    logic [7:0] ones;
    ones       = 8'hFF >> (8 - ir_width);
    d.kind     = OP_BYPASS;
    d.user_idx = 2'd0;
    if (op == ones)
      d.kind = OP_BYPASS;
    else if (int'(op) == EXTEST)
      d.kind = OP_EXTEST;
    else if (int'(op) == SAMPLE)
      d.kind = OP_SAMPLE;
    else if (int'(op) == IDCODE)
      d.kind = OP_IDCODE;
    else if (int'(op) >= USER_BASE && int'(op) < USER_BASE + num_udr) begin
      d.kind     = OP_USER;
      d.user_idx = 2'(int'(op) - USER_BASE);
    end
    return d;
  endfunction

endpackage

// File: rtl/jtag_tap_fsm.sv
// 16-state TAP controller; phase strobes are registered alongside the state so they
// are exactly "state == X" with no decode glitches.
module jtag_tap_fsm
  import jtag_tap_pkg::*;
(
  input  logic       tck,
  input  logic       trst,
  input  logic       tms,
  output tap_state_t state,
  output tap_state_t nxt,
  output logic       cap_dr,
  output logic       sh_dr,
  output logic       upd_dr,
  output logic       cap_ir,
  output logic       sh_ir,
  output logic       upd_ir
);

  always_comb begin
    nxt = state;
    case (state)
      TLR:        nxt = tms ? TLR       : RTI;
      RTI:        nxt = tms ? SELECT_DR : RTI;
      SELECT_DR:  nxt = tms ? SELECT_IR : CAPTURE_DR;
      CAPTURE_DR: nxt = tms ? EXIT1_DR  : SHIFT_DR;
      SHIFT_DR:   nxt = tms ? EXIT1_DR  : SHIFT_DR;
      EXIT1_DR:   nxt = tms ? UPDATE_DR : PAUSE_DR;
      PAUSE_DR:   nxt = tms ? EXIT2_DR  : PAUSE_DR;
      EXIT2_DR:   nxt = tms ? UPDATE_DR : SHIFT_DR;
      UPDATE_DR:  nxt = tms ? SELECT_DR : RTI;
      SELECT_IR:  nxt = tms ? TLR       : CAPTURE_IR;
      CAPTURE_IR: nxt = tms ? EXIT1_IR  : SHIFT_IR;
      SHIFT_IR:   nxt = tms ? EXIT1_IR  : SHIFT_IR;
      EXIT1_IR:   nxt = tms ? UPDATE_IR : PAUSE_IR;
      PAUSE_IR:   nxt = tms ? EXIT2_IR  : PAUSE_IR;
      EXIT2_IR:   nxt = tms ? UPDATE_IR : SHIFT_IR;
      UPDATE_IR:  nxt = tms ? SELECT_DR : RTI;
      default:    nxt = TLR;
    endcase
  end

  always_ff @(posedge tck or posedge trst) begin
    if (trst) begin
      state  <= TLR;
      cap_dr <= 1'b0;
      sh_dr  <= 1'b0;
      upd_dr <= 1'b0;
      cap_ir <= 1'b0;
      sh_ir  <= 1'b0;
      upd_ir <= 1'b0;
    end else begin
      state  <= nxt;
      cap_dr <= (nxt == CAPTURE_DR);
      sh_dr  <= (nxt == SHIFT_DR);
      upd_dr <= (nxt == UPDATE_DR);
      cap_ir <= (nxt == CAPTURE_IR);
      sh_ir  <= (nxt == SHIFT_IR);
      upd_ir <= (nxt == UPDATE_IR);
    end
  end

endmodule

// File: rtl/jtag_tap_multi_udr.sv
// TAP with IDCODE, BYPASS, EXTEST/SAMPLE boundary hook and NUM_UDR user data registers.
module jtag_tap_multi_udr
  import jtag_tap_pkg::*;
#(
  parameter int          IR_WIDTH   = 4,
  parameter int          NUM_UDR    = 2,
  parameter int          UDR_WIDTH  = 16,
  parameter logic [31:0] IDCODE_VAL = 32'h1000_0001
) (
  input  logic                           tck,
  input  logic                           trst,
  input  logic                           tms,
  input  logic                           tdi,
  output logic                           tdo,
  output logic                           tdo_en,
  output logic [3:0]                     tap_state,
  output logic [IR_WIDTH-1:0]            ir,
  input  logic                           bsr_so,
  output logic                           capture_dr,
  output logic                           shift_dr,
  output logic                           update_dr,
  output logic                           extest,
  input  logic [NUM_UDR*UDR_WIDTH-1:0]   udr_in,
  output logic [NUM_UDR*UDR_WIDTH-1:0]   udr_out,
  output logic [NUM_UDR-1:0]             udr_upd
);

  localparam logic [IR_WIDTH-1:0] IR_IDCODE  = IR_WIDTH'(IDCODE);
  localparam logic [IR_WIDTH-1:0] IR_CAPTURE = IR_WIDTH'(1);

  tap_state_t state, nxt;
  logic       cap_dr, sh_dr, upd_dr, cap_ir, sh_ir, upd_ir;

  jtag_tap_fsm u_fsm (
    .tck    (tck),
    .trst   (trst),
    .tms    (tms),
    .state  (state),
    .nxt    (nxt),
    .cap_dr (cap_dr),
    .sh_dr  (sh_dr),
    .upd_dr (upd_dr),
    .cap_ir (cap_ir),
    .sh_ir  (sh_ir),
    .upd_ir (upd_ir)
  );

  op_dec_t dec;
  logic    bsr_sel;

  always_comb dec = opcode_decode(8'(ir), IR_WIDTH, NUM_UDR);

  assign bsr_sel    = (dec.kind == OP_EXTEST) || (dec.kind == OP_SAMPLE);
  assign tap_state  = state;
  assign extest     = (dec.kind == OP_EXTEST);
  assign capture_dr = cap_dr & bsr_sel;
  assign shift_dr   = sh_dr & bsr_sel;
  assign update_dr  = upd_dr & bsr_sel;

  logic [IR_WIDTH-1:0]                ir_sr;
  logic [31:0]                        id_sr;
  logic                               byp_sr;
  logic [UDR_WIDTH-1:0]               udr_sr;
  logic [NUM_UDR-1:0][UDR_WIDTH-1:0]  udr_in_a;
  logic [NUM_UDR-1:0][UDR_WIDTH-1:0]  udr_hold;

  assign udr_in_a = udr_in;
  assign udr_out  = udr_hold;

  // One shared user shift register: only the selected USERk can be in a DR scan.
  always_ff @(posedge tck or posedge trst) begin
    if (trst) begin
      ir       <= IR_IDCODE;
      ir_sr    <= '0;
      id_sr    <= '0;
      byp_sr   <= 1'b0;
      udr_sr   <= '0;
      udr_hold <= '0;
      udr_upd  <= '0;
    end else begin
      if (nxt == TLR)
        ir <= IR_IDCODE;
      else if (upd_ir)
        ir <= ir_sr;

      if (cap_ir)
        ir_sr <= IR_CAPTURE;
      else if (sh_ir)
        ir_sr <= {tdi, ir_sr[IR_WIDTH-1:1]};

      if (cap_dr) begin
        case (dec.kind)
          OP_IDCODE: id_sr  <= IDCODE_VAL;
          OP_BYPASS: byp_sr <= 1'b0;
          OP_USER: begin
            for (int k = 0; k < NUM_UDR; k++)
              if (dec.user_idx == 2'(k)) udr_sr <= udr_in_a[k];
          end
          default: ;
        endcase
      end else if (sh_dr) begin
        case (dec.kind)
          OP_IDCODE: id_sr  <= {tdi, id_sr[31:1]};
          OP_BYPASS: byp_sr <= tdi;
          OP_USER:   udr_sr <= (udr_sr >> 1) | (UDR_WIDTH'(tdi) << (UDR_WIDTH - 1));
          default: ;
        endcase
      end

      // Hold register and pulse both land on Update-DR entry so they line up.
      udr_upd <= '0;
      if (nxt == UPDATE_DR && dec.kind == OP_USER) begin
        for (int k = 0; k < NUM_UDR; k++) begin
          if (dec.user_idx == 2'(k)) begin
            udr_hold[k] <= udr_sr;
            udr_upd[k]  <= 1'b1;
          end
        end
      end
    end
  end

  logic tdo_src;

  always_comb begin
    tdo_src = byp_sr;
    if (sh_ir)
      tdo_src = ir_sr[0];
    else begin
      case (dec.kind)
        OP_IDCODE:            tdo_src = id_sr[0];
        OP_USER:              tdo_src = udr_sr[0];
        OP_EXTEST, OP_SAMPLE: tdo_src = bsr_so;
        default:              tdo_src = byp_sr;
      endcase
    end
  end

  always_ff @(negedge tck or posedge trst) begin
    if (trst) begin
      tdo    <= 1'b0;
      tdo_en <= 1'b0;
    end else if (sh_dr || sh_ir) begin
      tdo    <= tdo_src;
      tdo_en <= 1'b1;
    end else begin
      tdo_en <= 1'b0;
    end
  end

endmodule

// File: tb/tb_jtag_tap_multi_udr.sv
// Directed bench for jtag_tap_multi_udr with default parameters.
module tb_jtag_tap_multi_udr;

  logic        tck = 1'b0;
  logic        trst, tms, tdi, bsr_so;
  logic        tdo, tdo_en, capture_dr, shift_dr, update_dr, extest;
  logic [3:0]  tap_state;
  logic [3:0]  ir;
  logic [31:0] udr_in, udr_out;
  logic [1:0]  udr_upd;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  int         plen  [16];
  logic [7:0] pbits [16];

  jtag_tap_multi_udr dut (
    .tck        (tck),
    .trst       (trst),
    .tms        (tms),
    .tdi        (tdi),
    .tdo        (tdo),
    .tdo_en     (tdo_en),
    .tap_state  (tap_state),
    .ir         (ir),
    .bsr_so     (bsr_so),
    .capture_dr (capture_dr),
    .shift_dr   (shift_dr),
    .update_dr  (update_dr),
    .extest     (extest),
    .udr_in     (udr_in),
    .udr_out    (udr_out),
    .udr_upd    (udr_upd)
  );

  always #5 tck = ~tck;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick(input logic t, input logic d);
    tms = t;
    tdi = d;
    @(posedge tck);
    @(negedge tck);
    #1;
  endtask

  task automatic load_ir(input logic [3:0] op, output logic [3:0] cap);
    cap = '0;
    tick(1, 0); tick(1, 0); tick(0, 0); tick(0, 0);
    for (int i = 0; i < 4; i++) begin
      cap[i] = tdo;
      tick(i == 3, op[i]);
    end
    tick(1, 0); tick(0, 0);
  endtask

  task automatic scan_dr(input int n, input logic [63:0] din, output logic [63:0] dout);
    dout = '0;
    tick(1, 0); tick(0, 0); tick(0, 0);
    for (int i = 0; i < n; i++) begin
      dout[i] = tdo;
      tick(i == n - 1, din[i]);
    end
  endtask

  task automatic test_reset();
    trst = 1'b1; tms = 1'b1; tdi = 1'b0; bsr_so = 1'b0; udr_in = '0;
    repeat (2) @(negedge tck);
    #1;
    chk_cnt++;
    if (tap_state !== 4'd0) $display("FAIL reset_state got=%0d exp=0", tap_state);
    else pass_cnt++;
    chk_cnt++;
    if (ir !== 4'd2) $display("FAIL reset_ir got=%0d exp=2", ir);
    else pass_cnt++;
    chk_cnt++;
    if (udr_out !== 32'h0 || udr_upd !== 2'b00)
      $display("FAIL reset_udr got=%h/%b exp=0/00", udr_out, udr_upd);
    else pass_cnt++;
    chk_cnt++;
    if (tdo !== 1'b0 || tdo_en !== 1'b0) $display("FAIL reset_tdo got=%b%b exp=00", tdo, tdo_en);
    else pass_cnt++;
    trst = 1'b0;
    tick(1, 0);
    tick(0, 0);
  endtask

  task automatic test_idcode();
    logic [31:0] got;
    got = '0;
    tick(1, 0); tick(0, 0); tick(0, 0);
    chk_cnt++;
    if (tdo_en !== 1'b1) $display("FAIL idcode_tdo_en got=%b exp=1", tdo_en);
    else pass_cnt++;
    for (int i = 0; i < 32; i++) begin
      got[i] = tdo;
      tick(i == 31, 1'b0);
    end
    chk_cnt++;
    if (got !== 32'h1000_0001) $display("FAIL idcode_value got=%h exp=10000001", got);
    else pass_cnt++;
    chk_cnt++;
    if (tdo_en !== 1'b0) $display("FAIL idcode_exit_tdo_en got=%b exp=0", tdo_en);
    else pass_cnt++;
    tick(1, 0); tick(0, 0);
  endtask

  task automatic test_tlr_all_states();
    logic [3:0] cap;
    plen  = '{3, 0, 1, 2, 3, 3, 4, 5, 4, 2, 3, 4, 4, 5, 6, 5};
    pbits = '{8'b111, 8'b0, 8'b1, 8'b01, 8'b001, 8'b101, 8'b0101, 8'b10101,
              8'b1101, 8'b11, 8'b011, 8'b0011, 8'b1011, 8'b01011, 8'b101011, 8'b11011};
    for (int s = 0; s < 16; s++) begin
      load_ir(4'hF, cap);
      for (int j = 0; j < plen[s]; j++) tick(pbits[s][j], 1'b0);
      chk_cnt++;
      if (tap_state !== 4'(s)) $display("FAIL walk_state_%0d got=%0d exp=%0d", s, tap_state, s);
      else pass_cnt++;
      repeat (5) tick(1, 0);
      chk_cnt++;
      if (tap_state !== 4'd0 || ir !== 4'd2)
        $display("FAIL tlr_from_%0d got state=%0d ir=%0d exp state=0 ir=2", s, tap_state, ir);
      else pass_cnt++;
      tick(0, 0);
    end
  endtask

  task automatic test_user1();
    logic [3:0]  cap;
    logic [63:0] dout;
    load_ir(4'd4, cap);
    chk_cnt++;
    if (cap !== 4'b0001 || ir !== 4'd4) $display("FAIL user1_ir got cap=%b ir=%0d exp 0001/4", cap, ir);
    else pass_cnt++;
    scan_dr(16, 64'hA5C3, dout);
    chk_cnt++;
    if (dout[15:0] !== 16'h0000) $display("FAIL user1_capture0 got=%h exp=0000", dout[15:0]);
    else pass_cnt++;
    tick(1, 0);
    chk_cnt++;
    if (udr_upd !== 2'b10 || udr_out !== 32'hA5C3_0000)
      $display("FAIL user1_update got upd=%b out=%h exp 10/a5c30000", udr_upd, udr_out);
    else pass_cnt++;
    tick(0, 0);
    chk_cnt++;
    if (udr_upd !== 2'b00) $display("FAIL user1_pulse_width got=%b exp=00", udr_upd);
    else pass_cnt++;
    udr_in = 32'h1234_0000;
    scan_dr(16, 64'h0, dout);
    chk_cnt++;
    if (dout[15:0] !== 16'h1234) $display("FAIL user1_capture got=%h exp=1234", dout[15:0]);
    else pass_cnt++;
    tick(1, 0); tick(0, 0);
    chk_cnt++;
    if (udr_out !== 32'h0) $display("FAIL user1_zero_update got=%h exp=00000000", udr_out);
    else pass_cnt++;
    // Capture then Exit1 -> Update with no shift
    tick(1, 0); tick(0, 0); tick(1, 0); tick(1, 0);
    chk_cnt++;
    if (udr_out !== 32'h1234_0000 || udr_upd !== 2'b10)
      $display("FAIL user1_noshift got out=%h upd=%b exp 12340000/10", udr_out, udr_upd);
    else pass_cnt++;
    tick(0, 0);
  endtask

  task automatic test_bypass();
    logic [3:0]  cap;
    logic [63:0] dout;
    load_ir(4'hF, cap);
    scan_dr(8, 64'hB1, dout);
    chk_cnt++;
    if (dout[7:0] !== 8'h62) $display("FAIL bypass_F got=%h exp=62", dout[7:0]);
    else pass_cnt++;
    tick(1, 0); tick(0, 0);
    load_ir(4'hC, cap);
    chk_cnt++;
    if (ir !== 4'hC) $display("FAIL bypass_C_ir got=%h exp=c", ir);
    else pass_cnt++;
    scan_dr(8, 64'hB1, dout);
    chk_cnt++;
    if (dout[7:0] !== 8'h62) $display("FAIL bypass_C got=%h exp=62", dout[7:0]);
    else pass_cnt++;
    tick(1, 0); tick(0, 0);
    chk_cnt++;
    if (udr_out !== 32'h1234_0000) $display("FAIL bypass_udr_kept got=%h exp=12340000", udr_out);
    else pass_cnt++;
  endtask

  task automatic test_pause();
    logic [3:0]  cap;
    logic [15:0] d;
    d = 16'hBEEF;
    load_ir(4'd3, cap);
    tick(1, 0); tick(0, 0); tick(0, 0);
    for (int i = 0; i < 8; i++) tick(i == 7, d[i]);
    tick(0, 0);
    repeat (10) tick(0, 0);
    chk_cnt++;
    if (tap_state !== 4'd6 || tdo_en !== 1'b0)
      $display("FAIL pause_state got=%0d en=%b exp=6/0", tap_state, tdo_en);
    else pass_cnt++;
    tick(1, 0); tick(0, 0);
    for (int i = 8; i < 16; i++) tick(i == 15, d[i]);
    tick(1, 0);
    chk_cnt++;
    if (udr_out !== 32'h1234_BEEF || udr_upd !== 2'b01)
      $display("FAIL pause_update got out=%h upd=%b exp 1234beef/01", udr_out, udr_upd);
    else pass_cnt++;
    tick(0, 0);
    load_ir(4'hF, cap);
    chk_cnt++;
    if (udr_out !== 32'h1234_BEEF) $display("FAIL ir_change_udr got=%h exp=1234beef", udr_out);
    else pass_cnt++;
  endtask

  task automatic test_extest();
    logic [3:0] cap;
    load_ir(4'd0, cap);
    chk_cnt++;
    if (extest !== 1'b1 || ir !== 4'd0) $display("FAIL extest_ir got ext=%b ir=%0d exp 1/0", extest, ir);
    else pass_cnt++;
    tick(1, 0); tick(0, 0);
    chk_cnt++;
    if (capture_dr !== 1'b1) $display("FAIL extest_capture got=%b exp=1", capture_dr);
    else pass_cnt++;
    bsr_so = 1'b1;
    tick(0, 0);
    chk_cnt++;
    if (shift_dr !== 1'b1 || tdo !== 1'b1) $display("FAIL extest_shift1 got sh=%b tdo=%b exp 1/1", shift_dr, tdo);
    else pass_cnt++;
    bsr_so = 1'b0;
    tick(0, 0);
    chk_cnt++;
    if (tdo !== 1'b0) $display("FAIL extest_shift0 got=%b exp=0", tdo);
    else pass_cnt++;
    tick(1, 0); tick(1, 0);
    chk_cnt++;
    if (update_dr !== 1'b1 || udr_upd !== 2'b00)
      $display("FAIL extest_update got upd_dr=%b udr_upd=%b exp 1/00", update_dr, udr_upd);
    else pass_cnt++;
    tick(0, 0);
  endtask

  task automatic test_trst_mid_shift();
    logic [3:0] cap;
    load_ir(4'd3, cap);
    tick(1, 0); tick(0, 0); tick(0, 0);
    repeat (3) tick(0, 1);
    chk_cnt++;
    if (tdo_en !== 1'b1) $display("FAIL trst_pre_en got=%b exp=1", tdo_en);
    else pass_cnt++;
    trst = 1'b1;
    #1;
    chk_cnt++;
    if (tdo_en !== 1'b0 || udr_out !== 32'h0 || udr_upd !== 2'b00)
      $display("FAIL trst_async got en=%b out=%h upd=%b exp 0/00000000/00", tdo_en, udr_out, udr_upd);
    else pass_cnt++;
    chk_cnt++;
    if (tap_state !== 4'd0 || ir !== 4'd2)
      $display("FAIL trst_state got state=%0d ir=%0d exp 0/2", tap_state, ir);
    else pass_cnt++;
    @(posedge tck); @(negedge tck); #1;
    chk_cnt++;
    if (udr_upd !== 2'b00 || udr_out !== 32'h0)
      $display("FAIL trst_hold got upd=%b out=%h exp 00/00000000", udr_upd, udr_out);
    else pass_cnt++;
    trst = 1'b0;
    tick(0, 0);
  endtask

  initial begin
    test_reset();
    test_idcode();
    test_tlr_all_states();
    test_user1();
    test_bypass();
    test_pause();
    test_extest();
    test_trst_mid_shift();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
